// File: rtl/axis_pack_pkg.sv
// Shared constants and helpers for the AXI-Stream lane packer.
package axis_pack_pkg;

  localparam int unsigned LANE_CNT_W = 8;

  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  // Bit offset of a lane inside a flattened multi-lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // ceil(log2(n)), never less than 1 so a counter always has a bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axis_lane_fifo.sv
// Single-lane FIFO: DEPTH entries, occupancy count one bit wider than the pointers.
module axis_lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_pack_data.sv
// Packs KERNEL_SIZE independent AXI-Stream lanes into one word per beat.
// Optional packet framing on m_axis_tlast is enabled by defining AXIS_PACK_TLAST_EN.
module axis_pack_data
  import axis_pack_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int PTR_WIDTH   = 2,
  parameter int PKT_BEATS   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KERNEL_SIZE-1:0]            s_axis_tvalid,
  output logic [KERNEL_SIZE-1:0]            s_axis_tready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
`ifdef AXIS_PACK_TLAST_EN
  ,
  output logic                              m_axis_tlast
`endif
);

  localparam lane_cnt_t N_LANES = lane_cnt_t'(KERNEL_SIZE);

  if (DEPTH != (1 << PTR_WIDTH) || DEPTH < 2 || PKT_BEATS < 1 || N_LANES == '0) begin : g_bad_param
    $error("axis_pack_data: inconsistent parameters");
  end

  logic [KERNEL_SIZE-1:0]            full;
  logic [KERNEL_SIZE-1:0]            empty;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] head_p0;
  logic                              pop_all;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] word_p1;
  logic                              vld_p1;

  // Ready depends only on registered occupancy, never on the downstream side.
  assign s_axis_tready = ~full;
  assign pop_all       = ~|empty && (!vld_p1 || m_axis_tready);

  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
    axis_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_axis_tvalid[i] & s_axis_tready[i]),
      .din   (s_axis_tdata[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .pop   (pop_all),
      .dout  (head_p0[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // p0 -> p1: lane heads captured as one packed output word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else if (pop_all) begin
      vld_p1  <= 1'b1;
      word_p1 <= head_p0;
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tdata  = word_p1;
  assign m_axis_tvalid = vld_p1;

`ifdef AXIS_PACK_TLAST_EN
  localparam int unsigned         BEAT_W    = cnt_w(PKT_BEATS);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  logic [BEAT_W-1:0] beat_cnt;
  logic              last_p1;

  // Every loaded word is handshaken in order, so counting loads tracks output beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      last_p1  <= 1'b0;
    end else if (pop_all) begin
      last_p1  <= (beat_cnt == LAST_BEAT);
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m_axis_tlast = last_p1 && vld_p1;
`endif

endmodule

// File: tb/tb_axis_pack_data.sv
// Scoreboard bench for axis_pack_data: queue-based reference model plus output monitor.
module tb_axis_pack_data;

  localparam int KS    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int PKT   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [KS*DW-1:0] s_tdata = '0;
  logic [KS-1:0]    s_tvalid = '0;
  wire  [KS-1:0]    s_tready;
  wire  [KS*DW-1:0] m_tdata;
  wire              m_tvalid;
  logic             m_tready = 1'b0;
`ifdef AXIS_PACK_TLAST_EN
  wire              m_tlast;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_pack_data #(
    .KERNEL_SIZE (KS),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .PTR_WIDTH   (PW),
    .PKT_BEATS   (PKT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
`ifdef AXIS_PACK_TLAST_EN
    ,
    .m_axis_tlast  (m_tlast)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: per-lane queues, one output slot, words awaiting handshake.
  logic [DW-1:0]    lane_q [KS][$];
  logic [KS*DW-1:0] exp_d[$];
  bit               exp_l[$];
  bit               m_out_full = 0;
  int               m_beat = 0;
  int               rx_cnt = 0;
  bit               chk_en = 0;

  function automatic bit model_all_ne();
    for (int i = 0; i < KS; i++)
      if (lane_q[i].size() == 0) return 0;
    return 1;
  endfunction

  bit [KS-1:0]      acc;
  bit               do_pop;
  logic [KS*DW-1:0] w;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KS; i++) lane_q[i].delete();
      exp_d.delete();
      exp_l.delete();
      m_out_full = 0;
      m_beat     = 0;
    end else begin
      for (int i = 0; i < KS; i++)
        acc[i] = s_tvalid[i] && (lane_q[i].size() < DEPTH);
      do_pop = model_all_ne() && (!m_out_full || m_tready);
      if (do_pop) begin
        for (int i = 0; i < KS; i++) w[i*DW +: DW] = lane_q[i].pop_front();
        exp_d.push_back(w);
        exp_l.push_back((m_beat % PKT) == PKT - 1);
        m_beat++;
        m_out_full = 1;
      end else if (m_tready) begin
        m_out_full = 0;
      end
      for (int i = 0; i < KS; i++)
        if (acc[i]) lane_q[i].push_back(s_tdata[i*DW +: DW]);
    end
  end

  bit               prev_stall = 0;
  logic [KS*DW-1:0] prev_data;
  logic [KS-1:0]    exp_rdy;

  always @(negedge clk) begin
    if (!chk_en || rst) begin
      prev_stall = 0;
    end else begin
      for (int i = 0; i < KS; i++) exp_rdy[i] = lane_q[i].size() < DEPTH;
      chk("m_tvalid", 64'(m_tvalid), 64'(m_out_full));
      chk("s_tready", 64'(s_tready), 64'(exp_rdy));
      if (prev_stall) chk("stall_hold", 64'(m_tdata), 64'(prev_data));
      if (m_tvalid) begin
        if (exp_d.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", m_tdata);
        end else begin
          chk("m_tdata", 64'(m_tdata), 64'(exp_d[0]));
`ifdef AXIS_PACK_TLAST_EN
          chk("m_tlast", 64'(m_tlast), 64'(exp_l[0]));
`endif
          if (m_tready) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            rx_cnt++;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    tick();
    rst = 1'b0;
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(3'b111));
`ifdef AXIS_PACK_TLAST_EN
    chk("rst_tlast", 64'(m_tlast), 64'(0));
`endif
    chk_en = 1;
  endtask

  task automatic drain();
    int n;
    n        = 0;
    m_tready = 1'b1;
    s_tvalid = '0;
    while ((exp_d.size() != 0 || model_all_ne()) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d words left required=0", exp_d.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int            base;
    int            idx [KS];
    int            cyc;
    logic [KS-1:0] rdy_snap;
    int            beat;
    logic [7:0]    lastmask;

    tick();
    do_reset();

    // Same-cycle push on all lanes, word appears two edges later for one cycle
    m_tready = 1'b1;
    s_tdata  = 24'h332211;
    s_tvalid = 3'b111;
    tick();
    s_tvalid = '0;
    s_tdata  = 24'($urandom);
    chk("t1_lat1", 64'(m_tvalid), 64'(0));
    tick();
    chk("t1_valid", 64'(m_tvalid), 64'(1));
    chk("t1_data", 64'(m_tdata), 64'(24'h332211));
    tick();
    chk("t1_gone", 64'(m_tvalid), 64'(0));

    // Lane 2 silent: no partial word, then one word after its push
    s_tdata  = 24'h5AB2B1;
    s_tvalid = 3'b011;
    tick();
    s_tvalid = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_nopartial", 64'(m_tvalid), 64'(0));
      tick();
    end
    s_tdata  = 24'hB37766;
    s_tvalid = 3'b100;
    tick();
    s_tvalid = '0;
    chk("t2_lat1", 64'(m_tvalid), 64'(0));
    tick();
    chk("t2_valid", 64'(m_tvalid), 64'(1));
    chk("t2_data", 64'(m_tdata), 64'(24'hB3B2B1));
    tick();
    chk("t2_gone", 64'(m_tvalid), 64'(0));

    // Fill lane 0 with downstream stalled, fifth push must be dropped
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_tdata  = {16'h0000, 8'(8'hA0 + k)};
      s_tvalid = 3'b001;
      tick();
    end
    chk("t3_full", 64'(s_tready[0]), 64'(0));
    s_tdata  = {16'h0000, 8'hEE};
    s_tvalid = 3'b001;
    tick();
    s_tvalid = '0;
    chk("t3_still_full", 64'(s_tready[0]), 64'(0));
    for (int k = 0; k < 4; k++) begin
      s_tdata  = {8'(8'hC0 + k), 8'(8'hB0 + k), 8'h00};
      s_tvalid = 3'b110;
      tick();
    end
    base = rx_cnt;
    drain();
    chk("t3_words", 64'(rx_cnt - base), 64'(4));

    // Ten beats with downstream ready toggling every cycle
    do_reset();
    for (int i = 0; i < KS; i++) idx[i] = 0;
    cyc  = 0;
    base = rx_cnt;
    while ((idx[0] < 10 || idx[1] < 10 || idx[2] < 10) && cyc < 200) begin
      for (int i = 0; i < KS; i++) begin
        s_tvalid[i]        = idx[i] < 10;
        s_tdata[i*DW +: DW] = 8'(idx[i] * 3 + i * 64 + 1);
      end
      m_tready = (cyc % 2) == 0;
      rdy_snap = s_tready;
      tick();
      for (int i = 0; i < KS; i++)
        if (s_tvalid[i] && rdy_snap[i]) idx[i]++;
      cyc++;
    end
    drain();
    chk("t4_words", 64'(rx_cnt - base), 64'(10));

    // Randomized traffic, tdata of idle lanes is noise
    do_reset();
    for (int k = 0; k < 400; k++) begin
      s_tvalid = KS'($urandom);
      s_tdata  = 24'($urandom);
      m_tready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain();

`ifdef AXIS_PACK_TLAST_EN
    // Eight back-to-back beats: tlast on beats 4 and 8 only
    do_reset();
    m_tready = 1'b1;
    beat     = 0;
    lastmask = '0;
    cyc      = 0;
    while (beat < 8 && cyc < 40) begin
      s_tvalid = (cyc < 8) ? 3'b111 : 3'b000;
      s_tdata  = 24'($urandom);
      tick();
      if (m_tvalid) begin
        lastmask[beat] = m_tlast;
        beat++;
      end
      cyc++;
    end
    s_tvalid = '0;
    chk("t6_beats", 64'(beat), 64'(8));
    chk("t6_lastmask", 64'(lastmask), 64'(8'h88));
    drain();
`endif

    // Reset with three words buffered discards them all
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_tdata  = 24'($urandom);
      s_tvalid = 3'b111;
      tick();
    end
    s_tvalid = '0;
    chk("t7_buffered", 64'(m_tvalid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_tvalid", 64'(m_tvalid), 64'(0));
    chk("t7_tready", 64'(s_tready), 64'(3'b111));
    chk("t7_tdata", 64'(m_tdata), 64'(0));
    m_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t7_nostale", 64'(m_tvalid), 64'(0));
      tick();
    end

    chk("final_empty", 64'(exp_d.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
